mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1: stage-3 instruction valid this cycle.
REQ-004 SHALL have port re, input, 1: load enable from MW control.
REQ-005 SHALL have port w_mask, input, 4: unshifted store mask from MW control (0001/0011/1111).
REQ-006 SHALL have port funct3, input, 3: load/store width and sign code.
REQ-007 SHALL have port addr, input, 32: byte address from ALU.
REQ-008 SHALL have port wdata, input, 32: unshifted store data (rs2).
REQ-009 SHALL have port stall, output, 1: freezes upstream pipeline while high.
REQ-010 SHALL have port load_data, output, 32: aligned and extended load result.
REQ-011 SHALL have port load_valid, output, 1: one-cycle pulse when load_data is updated.
REQ-012 SHALL have port dmem_req, output, 1: memory request valid.
REQ-013 SHALL have port dmem_we, output, 4: byte write enables, shifted to lane.
REQ-014 SHALL have port dmem_addr, output, 32: word address, addr[1:0] forced to 00.
REQ-015 SHALL have port dmem_wdata, output, 32: store data, shifted to lane.
REQ-016 SHALL have port dmem_gnt, input, 1: memory accepts request this cycle.
REQ-017 SHALL have port dmem_rvalid, input, 1: read data valid.
REQ-018 SHALL have port dmem_rdata, input, 32: raw read word.
REQ-019 SHALL have port misalign, output, 1: misaligned-access pulse; present only when MEM_MISALIGN_TRAP_EN is defined.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_R.
REQ-021 An access SHALL be accepted in IDLE when req_valid=1 and (re=1 or w_mask!=0); re=1 SHALL take priority, and w_mask SHALL then be ignored.
REQ-022 On accept, the unit SHALL register the word address, offset=addr[1:0], funct3, type, dmem_we=(w_mask<<offset) truncated to 4 bits, and dmem_wdata=wdata<<(8*offset); it SHALL then enter ISSUE.
REQ-023 stall SHALL be combinationally high in the accept cycle and in every ISSUE or WAIT_R cycle, and low otherwise.
REQ-024 In ISSUE, dmem_req SHALL be 1 and all dmem_* outputs SHALL be held stable until dmem_gnt=1.
REQ-025 For a load, dmem_we SHALL be 0000.
REQ-026 When dmem_gnt=1 in ISSUE, a store SHALL go to IDLE and a load SHALL go to WAIT_R; stall SHALL drop in the following cycle.
REQ-027 In WAIT_R, on dmem_rvalid=1, load_data SHALL register the extracted value, load_valid SHALL pulse for one cycle, and the FSM SHALL go to IDLE.
REQ-028 dmem_rvalid SHALL be ignored outside WAIT_R.
REQ-029 Extraction SHALL be: funct3 000 sign-extend byte at offset, 100 zero-extend byte, 001 sign-extend half at offset[1]*16, 101 zero-extend half, 010 full word, and any other code zero.
REQ-030 Minimum latency SHALL be: store 2 cycles accept-to-IDLE with immediate gnt; load 3 cycles to load_valid with immediate gnt and rvalid one cycle later.
REQ-031 load_data SHALL hold its last value until the next load completes.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, load_data=0, load_valid=0, and misalign=0; stall SHALL be 0 while in reset.
REQ-033 Reset during ISSUE or WAIT_R SHALL abandon the access, and a later dmem_rvalid SHALL be ignored.

Configuration
REQ-034 With MEM_MISALIGN_TRAP_EN defined, a half access at odd offset or a word access at offset!=0 SHALL not be issued; misalign SHALL pulse 1 cycle, the FSM SHALL stay IDLE, and stall SHALL stay 0.
REQ-035 Without MEM_MISALIGN_TRAP_EN, the misalign port SHALL be absent and such accesses SHALL be issued with a truncated mask and shift (e.g. SH at offset 3 gives dmem_we=1000).

Verification
REQ-036 SB with addr=0x1003, wdata=0x000000AB, immediate gnt -> dmem_addr=0x1000, dmem_we=1000, dmem_wdata=0xAB000000, stall high 2 cycles.
REQ-037 LB with addr=0x2001 and rdata=0x0000F500 -> load_data=0xFFFFFFF5, load_valid pulse; LBU with the same inputs -> 0x000000F5.
REQ-038 LHU with addr=0x2002 and rdata=0x8001_1234 -> load_data=0x00008001.
REQ-039 SW with gnt held low 4 cycles -> dmem_req and outputs stable for 5 cycles, stall high throughout, released 1 cycle after gnt.
REQ-040 Load in WAIT_R with reset_n pulsed low, then rvalid -> load_valid stays 0, stall 0, state IDLE.
REQ-041 With MEM_MISALIGN_TRAP_EN, LW at addr=0x3002 -> misalign=1 for 1 cycle, dmem_req never asserted.

Source files
------------

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between stage 3 and a req/gnt/rvalid data memory.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        re,
  input  logic [3:0]  w_mask,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        dmem_req,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  logic [1:0] state;
  logic       is_load;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic       accept;
  logic       mis;
  logic       issue;

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = 32'(b);
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = 32'(h);
      3'b101:  extract = {16'd0, h};
      3'b010:  extract = w;
      default: extract = 32'd0;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (funct3[1:0] == 2'b01 && addr[0]) ||
               (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid && (re || (w_mask != 4'b0000));
  assign issue  = accept && !mis;
  // Gated by reset_n so the pipeline is never frozen while the unit is held in reset.
  assign stall  = reset_n && (issue || (state != IDLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      is_load    <= 1'b0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      dmem_req   <= 1'b0;
      dmem_we    <= 4'b0000;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= ISSUE;
            is_load    <= re;
            off_q      <= addr[1:0];
            f3_q       <= funct3;
            dmem_req   <= 1'b1;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_we    <= re ? 4'b0000 : 4'(w_mask << addr[1:0]);
            dmem_wdata <= wdata << {addr[1:0], 3'b000};
          end
        end
        ISSUE: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state    <= is_load ? WAIT_R : IDLE;
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            load_data  <= extract(f3_q, off_q, dmem_rdata);
            load_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign <= 1'b0;
    else          misalign <= accept && mis;
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected memory requests and
// load results; a monitor pops and compares them whenever the DUT presents one.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, re;
  logic [3:0]  w_mask;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, dmem_req;
  logic [31:0] load_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;
  logic        dmem_gnt, dmem_rvalid;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .re(re), .w_mask(w_mask),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares every granted request and every load result against the queues.
  always @(negedge clk) begin
    req_t        e;
    logic [31:0] l;
    if (reset_n && dmem_req && dmem_gnt) begin
      if (req_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_req: addr 0x%08h with no expected request", dmem_addr);
      end else begin
        e = req_q.pop_front();
        chk("req_addr", dmem_addr, e.a);
        chk("req_we", {28'd0, dmem_we}, {28'd0, e.we});
        chk("req_wdata", dmem_wdata, e.wd);
      end
    end
    if (reset_n && load_valid) begin
      if (ld_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_load: load_data 0x%08h with no expected load", load_data);
      end else begin
        l = ld_q.pop_front();
        chk("load_data", load_data, l);
      end
    end
  end

  task automatic access(input bit ld, input logic [3:0] m, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int gd, input logic [31:0] ea, input logic [3:0] ewe,
                        input logic [31:0] ewd, input logic [31:0] eld, input int est);
    int sc;
    sc = 0;
    if (ld) ld_q.push_back(eld);
    req_q.push_back(req_t'{a: ea, we: ewe, wd: ewd});
    @(posedge clk); #1;
    req_valid = 1'b1; re = ld; w_mask = m; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk); if (stall) sc++;
    @(posedge clk); #1;
    req_valid = 1'b0; re = 1'b0; w_mask = 4'b0000; dmem_gnt = (gd == 0);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk); if (stall) sc++;
      chk("req_hold", {31'd0, dmem_req}, 32'd1);
      chk("addr_hold", dmem_addr, ea);
      chk("we_hold", {28'd0, dmem_we}, {28'd0, ewe});
      chk("wdata_hold", dmem_wdata, ewd);
      @(posedge clk); #1;
      dmem_gnt = (i == gd - 1);
    end
    @(negedge clk); if (stall) sc++;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    if (ld) begin
      dmem_rvalid = 1'b1; dmem_rdata = rd;
      @(negedge clk); if (stall) sc++;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    end
    @(negedge clk);
    chk("stall_release", {31'd0, stall}, 32'd0);
    chk("stall_cycles", 32'(sc), 32'(est));
    if (ld) begin
      chk("load_valid_pulse", {31'd0, load_valid}, 32'd1);
      @(negedge clk);
      chk("load_valid_one", {31'd0, load_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b1; re = 1'b1; w_mask = 4'b0000; funct3 = 3'b010;
    addr = 32'h2000; wdata = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {28'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    req_valid = 1'b0; re = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    //      ld m      f3      addr          wdata         rdata         gd ea            we      ewd           eld           stall
    access(0, 4'b0001, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0,        2);
    access(1, 4'b0000, 3'b000, 32'h0000_2001, 32'h0,        32'h0000_F500, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_FFF5, 3);
    access(1, 4'b0000, 3'b100, 32'h0000_2001, 32'h0,        32'h0000_F500, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_00F5, 3);
    access(1, 4'b0000, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_8001, 3);
    access(1, 4'b0000, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_8001, 3);
    access(1, 4'b1111, 3'b100, 32'h0000_2003, 32'h0,        32'h7F00_0000, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_007F, 3);
    access(1, 4'b0000, 3'b011, 32'h0000_2000, 32'h0,        32'hFFFF_FFFF, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_0000, 3);
    access(1, 4'b0000, 3'b010, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'hDEAD_BEEF, 3);
    access(0, 4'b1111, 3'b010, 32'h0000_4000, 32'h1234_5678, 32'h0,        4, 32'h0000_4000, 4'b1111, 32'h1234_5678, 32'h0,        6);
    access(0, 4'b0011, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 32'h0,        0, 32'h0000_1000, 4'b1100, 32'hBEEF_0000, 32'h0,        2);
    chk("load_data_hold", load_data, 32'hDEAD_BEEF);

    // A stray rvalid while idle must not produce a load result.
    @(posedge clk); #1 dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1 dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    @(negedge clk);
    chk("idle_rvalid_ignored", {31'd0, load_valid}, 32'd0);
    chk("idle_rvalid_data", load_data, 32'hDEAD_BEEF);

`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    req_valid = 1'b1; re = 1'b1; funct3 = 3'b010; addr = 32'h0000_3002;
    @(negedge clk);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 req_valid = 1'b0; re = 1'b0;
    @(negedge clk);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
    chk("mis_no_req2", {31'd0, dmem_req}, 32'd0);
`else
    access(0, 4'b0011, 3'b001, 32'h0000_1003, 32'h0000_BEEF, 32'h0, 0, 32'h0000_1000, 4'b1000, 32'hEF00_0000, 32'h0, 2);
`endif

    // Reset while waiting for read data abandons the load.
    req_q.push_back(req_t'{a: 32'h0000_2000, we: 4'b0000, wd: 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b1; re = 1'b1; funct3 = 3'b010; addr = 32'h0000_2000; wdata = 32'd0;
    @(posedge clk); #1 req_valid = 1'b0; re = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); #1 dmem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_r_stall", {31'd0, stall}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1 dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    @(negedge clk);
    chk("post_rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("post_rst_load_data", load_data, 32'd0);

    @(negedge clk);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk("load_queue_empty", 32'(ld_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
